// File: rtl/conv_mac_seq_if.sv
// Window-in / result-out handshake bundle for conv_mac_seq.
// The slave side is the MAC engine and the master side is its environment.
interface conv_mac_seq_if;
   logic         win_valid;
   logic         win_ready;
   logic [224:0] win_data;
   logic [224:0] w_data;
   logic [15:0]  bias;
   logic         out_valid;
   logic         out_ready;
   logic [8:0]   out_data;
   logic         busy;

   modport slave (
      input  win_valid, win_data, w_data, bias, out_ready,
      output win_ready, out_valid, out_data, busy
   );

   modport master (
      output win_valid, win_data, w_data, bias, out_ready,
      input  win_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/conv_mac_seq.sv
// Sequential 5x5 convolution MAC: 25 products, then bias add, ReLU,
// shift and saturation to 0..255, followed by a held valid/ready output.
module conv_mac_seq #(
   parameter int SHIFT = 8,
   parameter int ACC_W = 24
) (
   input  logic             clk,
   input  logic             rstn,
   conv_mac_seq_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_POST,
      S_OUT
   } state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic [4:0]                r_idx;
   logic signed [ACC_W-1:0]   r_acc;
   logic [224:0]              r_pix;
   logic [224:0]              r_wgt;
   logic signed [15:0]        r_bias;
   logic                      r_out_valid;
   logic [8:0]                r_out_data;

   logic                      w_accept;
   logic signed [8:0]         w_pix;
   logic signed [8:0]         w_wgt;
   logic signed [17:0]        w_prod;
   logic signed [ACC_W-1:0]   w_prod_ext;
   logic signed [ACC_W-1:0]   w_bias_ext;
   logic signed [ACC_W-1:0]   w_sum;
   logic [ACC_W-1:0]          w_relu;
   logic [ACC_W-1:0]          w_shift;
   logic [8:0]                w_sat;

   assign w_accept = bus.win_valid && (r_state == S_IDLE);

   // Capture registers shift down one element per MAC edge,
   // so the current operand pair is always in the low 9 bits.
   assign w_pix      = r_pix[8:0];
   assign w_wgt      = r_wgt[8:0];
   assign w_prod     = 18'(w_pix) * 18'(w_wgt);
   assign w_prod_ext = ACC_W'(w_prod);

   assign w_bias_ext = ACC_W'(r_bias);
   assign w_sum      = r_acc + w_bias_ext;
   assign w_relu     = w_sum[ACC_W-1] ? '0 : w_sum;
   assign w_shift    = w_relu >> SHIFT;
   assign w_sat      = (w_shift > ACC_W'(255)) ? 9'd255 : w_shift[8:0];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (w_accept) w_next = S_MAC;
         S_MAC:  if (r_idx == 5'd24) w_next = S_POST;
         S_POST: w_next = S_OUT;
         S_OUT:  if (bus.out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_idx       <= '0;
         r_acc       <= '0;
         r_pix       <= '0;
         r_wgt       <= '0;
         r_bias      <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_pix  <= bus.win_data;
                  r_wgt  <= bus.w_data;
                  r_bias <= bus.bias;
                  r_acc  <= '0;
                  r_idx  <= '0;
               end
            end
            S_MAC: begin
               r_acc <= r_acc + w_prod_ext;
               r_idx <= r_idx + 5'd1;
               r_pix <= r_pix >> 9;
               r_wgt <= r_wgt >> 9;
            end
            S_POST: begin
               r_out_data  <= w_sat;
               r_out_valid <= 1'b1;
            end
            S_OUT: begin
               if (bus.out_ready) r_out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.win_ready = (r_state == S_IDLE);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_conv_mac_seq.sv
// Directed and random checks of conv_mac_seq with SHIFT=0 and SHIFT=8
// instances driven in lockstep from the same stimulus.
module tb_conv_mac_seq;
   logic clk;
   logic rstn;
   int   n_chk;
   int   n_fail;

   conv_mac_seq_if if0 ();
   conv_mac_seq_if if8 ();

   conv_mac_seq #(.SHIFT(0), .ACC_W(24)) u_dut0 (
      .clk  (clk),
      .rstn (rstn),
      .bus  (if0.slave)
   );

   conv_mac_seq #(.SHIFT(8), .ACC_W(24)) u_dut8 (
      .clk  (clk),
      .rstn (rstn),
      .bus  (if8.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic set_in(input logic [224:0] pd, input logic [224:0] wd,
                         input logic [15:0] b, input logic v);
      if0.win_data = pd; if8.win_data = pd;
      if0.w_data = wd;   if8.w_data = wd;
      if0.bias = b;      if8.bias = b;
      if0.win_valid = v; if8.win_valid = v;
   endtask

   task automatic set_ordy(input logic r);
      if0.out_ready = r;
      if8.out_ready = r;
   endtask

   function automatic logic [224:0] fill(input logic [8:0] v);
      return {25{v}};
   endfunction

   function automatic logic [8:0] model(input logic [224:0] pd,
                                        input logic [224:0] wd,
                                        input logic [15:0] b,
                                        input int sh);
      longint acc;
      longint pp;
      longint ww;
      logic signed [8:0] p;
      logic signed [8:0] w;
      logic signed [15:0] bs;
      acc = 0;
      for (int k = 0; k < 25; k++) begin
         p = pd[9*k +: 9];
         w = wd[9*k +: 9];
         pp = p;
         ww = w;
         acc = acc + pp * ww;
      end
      bs = b;
      acc = acc + longint'(bs);
      if (acc < 0) acc = 0;
      acc = acc >>> sh;
      if (acc > 255) acc = 255;
      return acc[8:0];
   endfunction

   task automatic check_reset(input string tag);
      check({tag, "_v0"}, if0.out_valid, 0);
      check({tag, "_d0"}, if0.out_data, 0);
      check({tag, "_b0"}, if0.busy, 0);
      check({tag, "_r0"}, if0.win_ready, 1);
      check({tag, "_v8"}, if8.out_valid, 0);
      check({tag, "_d8"}, if8.out_data, 0);
   endtask

   task automatic run_win(input string tag, input logic [224:0] pd,
                          input logic [224:0] wd, input logic [15:0] b,
                          input logic [8:0] e0, input logic [8:0] e8,
                          input int hold);
      int n;
      check({tag, "_rdy"}, if0.win_ready, 1);
      set_in(pd, wd, b, 1'b1);
      @(posedge clk); #1;
      set_in(~pd, ~wd, ~b, 1'b0);
      check({tag, "_busy"}, if0.busy, 1);
      n = 0;
      while (!if0.out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_lat"}, n, 26);
      check({tag, "_d0"}, if0.out_data, e0);
      check({tag, "_d8"}, if8.out_data, e8);
      check({tag, "_v8"}, if8.out_valid, 1);
      for (int i = 0; i < hold; i++) begin
         set_in(fill(9'd7), fill(9'd7), 16'd99, 1'b1);
         @(posedge clk); #1;
         check({tag, "_hold_d"}, if0.out_data, e0);
         check({tag, "_hold_v"}, if0.out_valid, 1);
         check({tag, "_hold_r"}, if0.win_ready, 0);
      end
      set_in(fill(9'd7), fill(9'd7), 16'd99, 1'b0);
      set_ordy(1'b1);
      #1;
      check({tag, "_nobyp"}, if0.win_ready, 0);
      @(posedge clk); #1;
      set_ordy(1'b0);
      check({tag, "_drop"}, if0.out_valid, 0);
      check({tag, "_keep"}, if0.out_data, e0);
      check({tag, "_rdy1"}, if0.win_ready, 1);
   endtask

   logic [224:0] pd;
   logic [224:0] wd;
   logic [15:0]  bv;

   initial begin
      n_chk = 0;
      n_fail = 0;
      rstn = 1'b0;
      set_in('0, '0, '0, 1'b0);
      set_ordy(1'b0);
      #12;
      check_reset("rst");
      @(posedge clk); #1;
      rstn = 1'b1;

      run_win("unit", fill(9'd1), fill(9'd1), 16'd0, 9'd25, 9'd0, 0);
      run_win("sat", fill(9'd255), fill(9'd255), 16'd0, 9'd255, 9'd255, 0);
      run_win("relu", fill(9'd10), fill(9'h1FF), 16'd0, 9'd0, 9'd0, 0);
      run_win("b100", fill(9'd0), fill(9'd3), 16'd100, 9'd100, 9'd0, 0);
      run_win("b300", fill(9'd0), fill(9'd3), 16'd300, 9'd255, 9'd1, 0);
      run_win("bneg", fill(9'd0), fill(9'd3), 16'hFFFB, 9'd0, 9'd0, 0);
      run_win("shf", fill(9'd2), fill(9'd100), 16'd56, 9'd255, 9'd19, 0);
      run_win("min", fill(9'h100), fill(9'h100), 16'h7FFF,
              9'd255, 9'd255, 0);

      // pixel k = k+1; weight 0 = -1, weight 24 = 2, others 0 -> 49
      for (int k = 0; k < 25; k++) pd[9*k +: 9] = 9'(k + 1);
      wd = '0;
      wd[8:0] = 9'h1FF;
      wd[224:216] = 9'd2;
      run_win("order", pd, wd, 16'd0, 9'd49, 9'd0, 0);

      run_win("bp", fill(9'd4), fill(9'd2), 16'd10, 9'd210, 9'd0, 10);

      set_in(fill(9'd3), fill(9'd3), 16'd0, 1'b1);
      @(posedge clk); #1;
      set_in('0, '0, '0, 1'b0);
      repeat (12) @(posedge clk);
      #2;
      check("mid_busy", if0.busy, 1);
      rstn = 1'b0;
      #1;
      check_reset("mrst");
      @(posedge clk); #1;
      rstn = 1'b1;
      run_win("post", fill(9'd3), fill(9'd3), 16'd0, 9'd225, 9'd0, 0);

      for (int t = 0; t < 1000; t++) begin
         for (int k = 0; k < 25; k++) begin
            pd[9*k +: 9] = 9'($urandom);
            wd[9*k +: 9] = 9'(int'($urandom_range(0, 19)) - 10);
         end
         bv = 16'($urandom);
         run_win("rnd", pd, wd, bv, model(pd, wd, bv, 0),
                 model(pd, wd, bv, 8), int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/conv_mac_seq.md
CONV_MAC_SEQ -- requirements
Module: conv_mac_seq

Interface
REQ-001 SHALL have parameter SHIFT, default 8: arithmetic right-shift applied to the biased sum before saturation.
REQ-002 SHALL have parameter ACC_W, default 24: accumulator width in bits; must be >= 24.
REQ-003 SHALL have one clock; reset is asynchronous and active-low. Ports are named clk and rstn.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rstn, input, 1 bit: asynchronous active-low reset.
REQ-006 Port win_valid, input, 1 bit: a 5x5 window is presented.
REQ-007 Port win_ready, output, 1 bit: the block can accept a window.
REQ-008 Port win_data, input, 225 bits: 25 signed 9-bit pixels; element k is win_data[9k+8:9k], k = 0..24.
REQ-009 Port w_data, input, 225 bits: 25 signed 9-bit weights; element k is w_data[9k+8:9k].
REQ-010 Port bias, input, 16 bits: signed bias.
REQ-011 Port out_valid, output, 1 bit: a result is available.
REQ-012 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 Port out_data, output, 9 bits: signed result, always in the range 0..255.
REQ-014 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 SHALL implement the states IDLE, MAC, POST and OUT.
REQ-016 win_ready SHALL equal (state == IDLE); it is driven combinationally from registered state only.
REQ-017 On the edge where win_valid and win_ready are both high, the block SHALL:
  - capture win_data, w_data and bias into internal registers;
  - clear the accumulator and set idx = 0;
  - move to MAC.
REQ-018 In MAC, each edge SHALL do acc <= acc + sext(pix[idx] * w[idx]), using a full 18-bit signed product, then idx <= idx + 1.
REQ-019 On the edge that processes idx = 24, the state SHALL become POST; exactly 25 products are accumulated, in index order 0..24.
REQ-020 Inputs win_data, w_data and bias SHALL be ignored outside the accept edge; changing them mid-operation has no effect.
REQ-021 In POST, one edge SHALL compute s = acc + sext(bias) in ACC_W bits. It then applies, in order:
  - ReLU: s < 0 gives 0;
  - arithmetic shift right by SHIFT, truncating (floor);
  - saturation to 255.
REQ-022 The POST edge SHALL register the REQ-021 result into out_data, set out_valid = 1, and move to OUT.
REQ-023 Latency: if acceptance is edge T, out_valid SHALL be high immediately after edge T+26.
REQ-024 In OUT, out_data and out_valid SHALL hold stable until an edge with out_ready = 1. At that edge: out_valid <= 0, state <= IDLE.
REQ-025 win_ready SHALL NOT rise in the same cycle that the output is accepted (no bypass). Minimum window-to-window spacing is 28 cycles.
REQ-026 out_ready SHALL be ignored while out_valid = 0.
REQ-027 win_valid SHALL be ignored outside IDLE; a window presented while busy is not captured.
REQ-028 The accumulator SHALL NOT overflow: |25 * 256 * 256 + 32768| < 2^(ACC_W-1) for ACC_W = 24. No wrap logic is required.
REQ-029 out_data SHALL change only on the POST edge or on reset.

Reset
REQ-030 While rstn = 0, asynchronously:
  - state = IDLE, idx = 0, acc = 0, all capture registers = 0;
  - out_valid = 0, out_data = 0, busy = 0, win_ready = 1.
REQ-031 Reset asserted in any state SHALL abort the operation in progress with no output produced. The first acceptance can occur on the first rising edge after rstn deasserts.

Verification
REQ-032 Unit case: all pixels 1, all weights 1, bias 0, SHIFT = 0 -> out_data = 25 after 26 edges, out_valid = 1.
REQ-033 Saturation and ReLU:
  - pixels 255, weights 255, bias 0, SHIFT = 8 -> acc 1625625, shifted 6350, out_data = 255;
  - pixels 10, weights -1, bias 0 -> out_data = 0.
REQ-034 Bias path, pixels 0, SHIFT = 0:
  - bias 100 -> out_data = 100;
  - bias 300 -> out_data = 255;
  - bias -5 -> out_data = 0.
REQ-035 Back-pressure: hold out_ready = 0 for 10 cycles after out_valid -> out_data stable, win_ready = 0, and a concurrent win_valid is not captured. Then raise out_ready -> out_valid drops, and win_ready = 1 one cycle later.
REQ-036 Mid-operation reset: pulse rstn low at idx = 12 -> all outputs reach their REQ-030 values immediately. A new window then yields a correct result with no residue from the aborted one.
REQ-037 Random regression: 1000 windows of random pixels, weights in -10..9, random bias and random out_ready -> every out_data matches a bit-accurate software model in REQ-021 order, with no window dropped or duplicated.
